note_tone_gen: RTL and testbench
================================

NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have parameter TABLE_SHIFT, default 0: extra right-shift applied to every half-period table entry, used to shorten simulation.
REQ-002 SHALL have port clk  input  1  single system clock (50 MHz), all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port layer_in  input  3  one-hot layer select from the upstream layer FSM (001=L1, 010=L2, 100=L3), synchronous to clk.
REQ-005 SHALL have port note_keys  input  7  raw asynchronous note switches, bit0=C ... bit6=B, active-high.
REQ-006 SHALL have port tone_out  output  1  square-wave audio drive.
REQ-007 SHALL have port playing  output  1  high while a valid note is sounding.
REQ-008 SHALL have port note_idx  output  3  selected note, 0=silent, 1..7 = C..B.

Function
REQ-009 SHALL pass note_keys through a 2-flop synchronizer before any use.
REQ-010 SHALL select the lowest-index set synchronized key (C highest priority); no key set = silent.
REQ-011 SHALL register selection (note_idx, playing, effective layer) in one select register fed by synchronizer stage 2 and layer_in directly.
REQ-012 SHALL make a note_keys change visible on note_idx/playing after the 3rd rising clk edge sampling it; a layer_in change after the 1st edge.
REQ-013 SHALL treat layer_in not one-hot (000, or 2+ bits set) as silent: playing=0, note_idx=0.
REQ-014 SHALL use L1 base half-periods (cycles): C 95556, D 85131, E 75842, F 71586, G 63776, A 56818, B 50619.
REQ-015 SHALL derive half-period H = base >> (layer shift + TABLE_SHIFT), layer shift 0/1/2 for L1/L2/L3, truncating.
REQ-016 SHALL hold a 17-bit half-period counter counting 0..H-1.
REQ-017 SHALL, when playing and counter==H-1, reload counter to 0 and toggle tone_out in the same edge; tone period = 2H cycles, 50% duty.
REQ-018 SHALL, when the registered (note_idx, layer) pair changes while playing, reset counter to 0 on that edge and keep tone_out unchanged (no extra edge inserted).
REQ-019 SHALL, when not playing, hold counter at 0 and force tone_out to 0 on the next edge.
REQ-020 SHALL, on transition silent -> playing, start counting from 0 with tone_out=0, first toggle H cycles after playing rises.
REQ-021 SHALL never let counter exceed H-1; if H shrinks mid-count the REQ-018 restart applies.
REQ-022 SHALL make playing=1 iff note_idx!=0.

Reset
REQ-023 SHALL on resetn=0 asynchronously clear synchronizer flops, select register, counter, tone_out=0, playing=0, note_idx=0.
REQ-024 SHALL, on reset mid-tone, drop tone_out to 0 immediately; after release resume only via REQ-012 latency.
REQ-025 SHALL release reset synchronously-safe: first state update on the first rising clk after resetn rises.

Verification
REQ-026 SHALL cover: reset, layer_in=001, note_keys=0100000 (A) -> playing=1, note_idx=6 after 3 edges; tone_out toggles every 56818 cycles.
REQ-027 SHALL cover: A held, layer_in 001->100 -> after 1 edge counter restarts, half-period 14204, tone_out level unchanged at switch.
REQ-028 SHALL cover: note_keys=1000001 (C+B), layer 010 -> note_idx=1, half-period 47778.
REQ-029 SHALL cover: layer_in=011 with key C pressed -> playing=0, note_idx=0, tone_out=0 next edge.
REQ-030 SHALL cover: TABLE_SHIFT=8, layer 001, E held, resetn pulsed low mid-period -> tone_out=0 immediately, on release playing back after 3 edges, half-period 296.
REQ-031 SHALL cover: key released while tone_out=1 -> playing falls after 3 edges, tone_out=0 following edge, counter held 0.

Source files
------------

// File: rtl/note_tone_gen.sv
// note_tone_gen
//    Square-wave note generator. Seven note switches are synchronized,
//    priority-encoded (C wins) and combined with a one-hot octave layer to
//    select a half-period; a 17-bit up-counter then toggles tone_out every
//    half-period.
//
// Parameters
//    TABLE_SHIFT  extra right-shift on every half-period table entry
//
// Ports
//    clk        in   system clock, 50 MHz, rising edge
//    resetn     in   asynchronous active-low reset
//    layer_in   in   [2:0] one-hot layer select (001=L1, 010=L2, 100=L3)
//    note_keys  in   [6:0] raw asynchronous note switches, bit0=C .. bit6=B
//    tone_out   out  square-wave audio drive
//    playing    out  high while a valid note sounds
//    note_idx   out  [2:0] selected note, 0=silent, 1..7=C..B
//
// Tone FSM
//    state    | meaning
//    ---------+----------------------------------------------------------
//    ST_IDLE  | silent (or first cycle after playing rose), tone low, count 0
//    ST_LOW   | sounding, low half of the square wave
//    ST_HIGH  | sounding, high half of the square wave

module note_tone_gen #(
   parameter int TABLE_SHIFT = 0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] layer_in,
   input  logic [6:0] note_keys,
   output logic       tone_out,
   output logic       playing,
   output logic [2:0] note_idx
);

   // bit0 of the encoding is the audio level, so tone_out is a plain flop
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOW  = 2'b10,
      ST_HIGH = 2'b11
   } tone_state_t;

   tone_state_t state_q, state_d;

   logic [6:0]  keys_s1, keys_s2;
   logic [2:0]  key_sel;
   logic        layer_ok;
   logic [1:0]  layer_code;
   logic [2:0]  sel_idx_d;
   logic [1:0]  sel_lay_d;
   logic [1:0]  layer_q;
   logic        pair_change;
   logic [16:0] half_raw, half_cur, half_m1;
   logic [16:0] cnt_q, cnt_d;

   function automatic logic [16:0] base_half(input logic [2:0] idx);
      case (idx)
         3'd1:    base_half = 17'd95556;
         3'd2:    base_half = 17'd85131;
         3'd3:    base_half = 17'd75842;
         3'd4:    base_half = 17'd71586;
         3'd5:    base_half = 17'd63776;
         3'd6:    base_half = 17'd56818;
         3'd7:    base_half = 17'd50619;
         default: base_half = 17'd0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         keys_s1 <= '0;
         keys_s2 <= '0;
      end else begin
         keys_s1 <= note_keys;
         keys_s2 <= keys_s1;
      end
   end

   // scan from B down to C so the lowest set key ends up winning
   always_comb begin
      key_sel = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (keys_s2[i]) key_sel = 3'(i + 1);
      end
   end

   always_comb begin
      layer_ok   = 1'b1;
      layer_code = 2'd0;
      case (layer_in)
         3'b001:  layer_code = 2'd0;
         3'b010:  layer_code = 2'd1;
         3'b100:  layer_code = 2'd2;
         default: layer_ok   = 1'b0;
      endcase
   end

   assign sel_idx_d = layer_ok ? key_sel    : 3'd0;
   assign sel_lay_d = layer_ok ? layer_code : 2'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         note_idx <= 3'd0;
         layer_q  <= 2'd0;
         playing  <= 1'b0;
      end else begin
         note_idx <= sel_idx_d;
         layer_q  <= sel_lay_d;
         playing  <= (sel_idx_d != 3'd0);
      end
   end

   // Restart is keyed on the value the select register is about to load, so
   // the counter starts over on the same edge the new half-period takes
   // effect and never runs past a freshly shortened limit.
   assign pair_change = (sel_idx_d != note_idx) || (sel_lay_d != layer_q);

   always_comb begin
      half_raw = base_half(note_idx) >> (int'(layer_q) + TABLE_SHIFT);
      half_cur = (half_raw == 17'd0) ? 17'd1 : half_raw;
      half_m1  = half_cur - 17'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!playing) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (pair_change) begin
         // level is kept; leaving IDLE here just means we are sounding low
         cnt_d = '0;
         if (state_q == ST_IDLE) state_d = ST_LOW;
      end else if (cnt_q >= half_m1) begin
         cnt_d   = '0;
         state_d = (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
      end else begin
         cnt_d = cnt_q + 17'd1;
         if (state_q == ST_IDLE) state_d = ST_LOW;
      end
   end

   assign tone_out = state_q[0];

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed scenarios plus randomized key/layer
// sequences, every edge compared against a time-based reference model.
module tb_note_tone_gen;

   localparam int TS = 8;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] layer_in = 3'b000;
   logic [6:0] note_keys = 7'd0;
   logic       tone_out;
   logic       playing;
   logic [2:0] note_idx;

   note_tone_gen #(.TABLE_SHIFT(TS)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .layer_in  (layer_in),
      .note_keys (note_keys),
      .tone_out  (tone_out),
      .playing   (playing),
      .note_idx  (note_idx)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   int base_tbl [7] = '{95556, 85131, 75842, 71586, 63776, 56818, 50619};
   logic [6:0] key_h1 = 7'd0;   // keys sampled one edge ago
   logic [6:0] key_h2 = 7'd0;   // keys sampled two edges ago
   int m_idx = 0, m_lay = 0, m_play = 0, m_tone = 0;
   int seg_start = 0, seg_level = 0;
   int cyc = 0;

   function automatic int half_of(input int idx, input int lay);
      int h;
      h = base_tbl[idx-1] >> (lay + TS);
      if (h < 1) h = 1;
      return h;
   endfunction

   function automatic int prio(input logic [6:0] k);
      for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
      return 0;
   endfunction

   function automatic int layer_code(input logic [2:0] l);
      case (l)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   task automatic model_clear();
      key_h1 = 7'd0; key_h2 = 7'd0;
      m_idx = 0; m_lay = 0; m_play = 0; m_tone = 0;
      seg_start = cyc; seg_level = 0;
   endtask

   // one rising edge: advance the model from the sampled inputs, then compare
   task automatic tick();
      int lc, n_idx, n_lay;
      @(posedge clk);
      cyc++;
      lc    = layer_code(layer_in);
      n_idx = (lc < 0) ? 0 : prio(key_h2);
      n_lay = (lc < 0) ? 0 : lc;
      key_h2 = key_h1;
      key_h1 = note_keys;
      if (m_play == 0) begin
         m_tone = 0; seg_start = cyc; seg_level = 0;
      end else if (n_idx != m_idx || n_lay != m_lay) begin
         seg_start = cyc; seg_level = m_tone;
      end else begin
         m_tone = seg_level ^ (((cyc - seg_start) / half_of(m_idx, m_lay)) & 1);
      end
      m_idx = n_idx; m_lay = n_lay; m_play = (n_idx != 0) ? 1 : 0;
      #1;
      check("tone_out", int'(tone_out), m_tone);
      check("playing", int'(playing), m_play);
      check("note_idx", int'(note_idx), m_idx);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // edges until tone_out changes level; -1 if the bound expires
   task automatic wait_toggle(input int limit, output int n);
      logic t0;
      t0 = tone_out;
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (tone_out !== t0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset(input int hold);
      #3 resetn = 1'b0;
      #1;
      check("rst_tone", int'(tone_out), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_note_idx", int'(note_idx), 0);
      model_clear();
      repeat (hold) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   int n;

   initial begin
      #5;
      check("por_tone", int'(tone_out), 0);
      check("por_playing", int'(playing), 0);
      check("por_note_idx", int'(note_idx), 0);
      @(negedge clk);
      resetn = 1'b1;

      // A on layer 1: three-edge key latency, half-period 56818>>8
      layer_in = 3'b001; note_keys = 7'b0100000;
      ticks(2);
      check("a_latency_early", int'(playing), 0);
      tick();
      check("a_playing", int'(playing), 1);
      check("a_idx", int'(note_idx), 6);
      for (int k = 0; k < 3; k++) begin
         wait_toggle(400, n);
         check("a_l1_half", n, 221);
      end
      ticks(100);

      // switch to layer 3 mid-period: one-edge latency, level kept, restart
      layer_in = 3'b100;
      tick();
      check("l3_level_kept", int'(tone_out), 1);
      wait_toggle(400, n);
      check("a_l3_half", n, 55);
      wait_toggle(400, n);
      check("a_l3_half2", n, 55);

      // C+B on layer 2: C wins
      note_keys = 7'b1000001; layer_in = 3'b010;
      ticks(3);
      check("cb_idx", int'(note_idx), 1);
      wait_toggle(400, n);
      check("c_l2_half", n, 186);

      // non-one-hot layer silences on the next edge, tone low the edge after
      layer_in = 3'b011;
      tick();
      check("bad_layer_playing", int'(playing), 0);
      check("bad_layer_idx", int'(note_idx), 0);
      tick();
      check("bad_layer_tone", int'(tone_out), 0);

      // E held, released while tone high
      layer_in = 3'b001; note_keys = 7'b0000100;
      ticks(3);
      check("e_idx", int'(note_idx), 3);
      wait_toggle(600, n);
      check("e_l1_half", n, 296);
      note_keys = 7'd0;
      ticks(2);
      check("rel_still_playing", int'(playing), 1);
      tick();
      check("rel_playing_low", int'(playing), 0);
      check("rel_tone_held", int'(tone_out), 1);
      tick();
      check("rel_tone_low", int'(tone_out), 0);
      ticks(20);

      // reset pulse mid-period while tone high
      note_keys = 7'b0000100;
      ticks(3);
      wait_toggle(600, n);
      check("e_first_half", n, 296);
      ticks(100);
      do_reset(3);
      ticks(2);
      check("post_rst_early", int'(playing), 0);
      tick();
      check("post_rst_playing", int'(playing), 1);
      wait_toggle(600, n);
      check("post_rst_half", n, 296);

      // randomized sequences
      for (int s = 0; s < 80; s++) begin
         int r, dur;
         r = $urandom_range(0, 3);
         if (r == 0)      note_keys = 7'd0;
         else if (r == 1) note_keys = 7'(1 << $urandom_range(0, 6));
         else             note_keys = 7'($urandom_range(1, 127));
         r = $urandom_range(0, 9);
         if (r < 8) begin
            case ($urandom_range(0, 2))
               0:       layer_in = 3'b001;
               1:       layer_in = 3'b010;
               default: layer_in = 3'b100;
            endcase
         end else begin
            layer_in = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 3) == 0) dur = $urandom_range(1, 3);
         else                           dur = $urandom_range(10, 600);
         ticks(dur);
         if ($urandom_range(0, 11) == 0) do_reset($urandom_range(1, 4));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
